// File: rtl/elevator_dispatch_ctrl.sv
// SCAN dispatcher for a small elevator car. It latches floor calls, paces travel and door
// dwell with one shared timer, and lets overload and fire recall override normal service.
module elevator_dispatch_ctrl #(
  parameter int unsigned NUM_FLOORS = 4,
  parameter int unsigned FLOOR_W    = 2,
  parameter int unsigned TRAVEL_CYC = 8,
  parameter int unsigned DOOR_CYC   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  overload,
  input  logic                  firealarm,
  input  logic                  person_detected,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  door_closed,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  arrived,
  output logic                  fire_mode
);

  localparam int unsigned TimerMax = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int unsigned TimerW   = $clog2(TimerMax);
  localparam logic [TimerW-1:0]  TravelLast = TimerW'(TRAVEL_CYC - 1);
  localparam logic [TimerW-1:0]  DoorLast   = TimerW'(DOOR_CYC - 1);
  localparam logic [FLOOR_W-1:0] TopFloor   = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {StIdle, StMove, StDoor, StFire} state_e;

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d, next_floor;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    dir_up_q, dir_up_d;
  logic                    moving_q, moving_d;
  logic                    door_open_q, door_open_d;
  logic                    arrived_q, arrived_d;
  logic                    fire_mode_q, fire_mode_d;
  logic                    calls_above, calls_below, calls_ahead;

  // Where the next step lands, and which latched calls lie above, below and beyond it.
  always_comb begin
    next_floor = cur_floor_q;
    if (dir_up_q && cur_floor_q != TopFloor) begin
      next_floor = cur_floor_q + 1'b1;
    end else if (!dir_up_q && cur_floor_q != '0) begin
      next_floor = cur_floor_q - 1'b1;
    end
    calls_above = 1'b0;
    calls_below = 1'b0;
    calls_ahead = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && FLOOR_W'(i) > cur_floor_q) calls_above = 1'b1;
      if (pending_q[i] && FLOOR_W'(i) < cur_floor_q) calls_below = 1'b1;
      if (pending_q[i] && dir_up_q && FLOOR_W'(i) > next_floor) calls_ahead = 1'b1;
      if (pending_q[i] && !dir_up_q && FLOOR_W'(i) < next_floor) calls_ahead = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    timer_d     = timer_q;
    moving_d    = moving_q;
    door_open_d = door_open_q;
    arrived_d   = 1'b0;
    fire_mode_d = fire_mode_q;
    pending_d   = pending_q | ((fire_mode_q || firealarm) ? '0 : req);

    if (firealarm && state_q != StFire) begin
      // Recall abandons any segment in flight; the car restarts from the floor it last passed.
      state_d     = StFire;
      fire_mode_d = 1'b1;
      pending_d   = '0;
      timer_d     = '0;
      if (cur_floor_q == '0) begin
        door_open_d = 1'b1;
        moving_d    = 1'b0;
        arrived_d   = 1'b1;
      end else begin
        door_open_d = 1'b0;
        moving_d    = 1'b1;
        dir_up_d    = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pending_q[cur_floor_q]) begin
            state_d                = StDoor;
            door_open_d            = 1'b1;
            timer_d                = '0;
            pending_d[cur_floor_q] = 1'b0;
          end else if (!overload && (calls_above || calls_below)) begin
            state_d  = StMove;
            moving_d = 1'b1;
            timer_d  = '0;
            dir_up_d = (dir_up_q && calls_above) || !calls_below;
          end
        end
        StMove: begin
          if (timer_q != TravelLast) begin
            timer_d = timer_q + 1'b1;
          end else begin
            timer_d     = '0;
            cur_floor_d = next_floor;
            if (pending_q[next_floor]) begin
              state_d               = StDoor;
              moving_d              = 1'b0;
              door_open_d           = 1'b1;
              arrived_d             = 1'b1;
              pending_d[next_floor] = 1'b0;
            end else if (!calls_ahead) begin
              state_d  = StIdle;
              moving_d = 1'b0;
            end
          end
        end
        StDoor: begin
          door_open_d            = 1'b1;
          pending_d[cur_floor_q] = 1'b0;
          if (person_detected || overload) begin
            timer_d = '0;
          end else if (timer_q == DoorLast) begin
            state_d     = StIdle;
            door_open_d = 1'b0;
            timer_d     = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StFire: begin
          pending_d = '0;
          if (!firealarm) begin
            state_d     = StDoor;
            fire_mode_d = 1'b0;
            door_open_d = 1'b1;
            moving_d    = 1'b0;
            timer_d     = '0;
          end else if (cur_floor_q != '0) begin
            moving_d    = 1'b1;
            door_open_d = 1'b0;
            if (timer_q == TravelLast) begin
              timer_d     = '0;
              cur_floor_d = cur_floor_q - 1'b1;
              if (cur_floor_q == FLOOR_W'(1)) begin
                moving_d    = 1'b0;
                door_open_d = 1'b1;
                arrived_d   = 1'b1;
              end
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end else begin
            door_open_d = 1'b1;
            moving_d    = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      timer_q     <= '0;
      pending_q   <= '0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      arrived_q   <= 1'b0;
      fire_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
      arrived_q   <= arrived_d;
      fire_mode_q <= fire_mode_d;
    end
  end

  assign cur_floor   = cur_floor_q;
  assign moving      = moving_q;
  assign dir_up      = dir_up_q;
  assign door_open   = door_open_q;
  assign door_closed = ~door_open_q;
  assign pending     = pending_q;
  assign arrived     = arrived_q;
  assign fire_mode   = fire_mode_q;

endmodule
